axi4_burst_master: RTL and testbench
====================================

// Module: axi4_burst_master
// PURPOSE
//  AXI4 initiator that drives the memory-mapped slave from a simple command port.
//  Issues one INCR write or read burst per accepted command: streams write beats in and read beats out.
//  Reports burst completion with an aggregated response.
//  Sits on the same arb_if bundle as the slave: stimulus engine for directed tests, reusable bus master.
// PARAMETERS
//  ADDR_WIDTH  16  byte address width of AWADDR/ARADDR/cmd_addr
//  DATA_WIDTH  32  bus data width (8..1024, power of 2); AxSIZE = $clog2(DATA_WIDTH/8)
// PORTS
//  ACLK             in   1           bus clock, all logic on rising edge
//  ARESETn          in   1           asynchronous active-low reset
//  cmd_valid        in   1           command request
//  cmd_ready        out  1           command accepted when cmd_valid&&cmd_ready
//  cmd_write        in   1           1=write burst, 0=read burst
//  cmd_addr         in   ADDR_WIDTH  burst start byte address (size-aligned)
//  cmd_len          in   8           beats-1 (AXI LEN encoding)
//  wd_data          in   DATA_WIDTH  write beat payload
//  wd_valid/wd_ready in/out 1        write beat stream handshake
//  rd_data          out  DATA_WIDTH  read beat payload
//  rd_valid/rd_last out  1           read beat valid / last beat of burst
//  rd_ready         in   1           read beat sink ready
//  done             out  1           1-cycle pulse: burst complete
//  done_resp        out  2           write: BRESP; read: max RRESP over burst
//  AWADDR/ARADDR    out  ADDR_WIDTH  latched cmd_addr
//  AWLEN/ARLEN      out  8           latched cmd_len
//  AWSIZE/ARSIZE    out  3           constant $clog2(DATA_WIDTH/8)
//  AWBURST/ARBURST  out  2           constant 2'b01 (INCR)
//  AWVALID/ARVALID  out  1           address valid; AWREADY/ARREADY in 1
//  WDATA/WSTRB      out  DATA_WIDTH, DATA_WIDTH/8  WDATA=wd_data, WSTRB all ones
//  WVALID/WLAST     out  1           WREADY in 1
//  BRESP/BVALID     in   2/1         BREADY out 1
//  RDATA/RRESP      in   DATA_WIDTH/2  RLAST/RVALID in 1, RREADY out 1
// BEHAVIOUR
//  Reset: state IDLE, all *VALID/*READY outputs 0, done 0, done_resp 0, beat counter 0; abandons any burst.
//  FSM: IDLE -> WADDR|RADDR on cmd handshake (cmd_write selects); cmd fields latched.
//  cmd_ready = (state==IDLE).
//  WADDR: AWVALID=1, held with AWADDR/AWLEN stable until AWREADY; then WDATA.
//  WDATA: no W beat before AW handshake.
//   WVALID=wd_valid, wd_ready=WREADY.
//   Beat counter increments on WVALID&&WREADY.
//   WLAST=(cnt==len).
//   Last handshake -> WRESP, counter cleared.
//  WRESP: BREADY=1; on BVALID -> IDLE, done=1 next cycle with done_resp=BRESP.
//  RADDR: ARVALID held until ARREADY; then RDATA.
//  RDATA: RREADY=rd_ready, rd_valid=RVALID, rd_data=RDATA, rd_last=RLAST.
//   Worst response accumulated as numeric max of RRESP.
//   RVALID&&RREADY&&RLAST -> IDLE, done pulse with accumulated resp.
//   Accumulator cleared at cmd accept.
//  Read beat count mismatch: RLAST with cnt!=len forces done_resp=2'b10 (SLVERR); beats past len are consumed, not forwarded.
//  done and cmd_ready may both be 1 in the same cycle; back-to-back commands need no idle gap.
//  cmd_len=0: single beat, WLAST on first beat.
//  Address arithmetic: none internal; slave increments.
// CONFIGURATION
//  AXI4_4K_BOUNDARY_CHECK_EN defined: at cmd accept, a burst is rejected when
//   cmd_addr[ADDR_WIDTH-1:12] != (cmd_addr + (cmd_len+1)*DATA_WIDTH/8 - 1)[ADDR_WIDTH-1:12].
//   Rejected burst: no AW/AR/W activity, done pulse next cycle with done_resp=2'b10; returns IDLE.
//  Not defined: no check, all commands issued as given.
// TESTING
//  1. Write addr 0x100, len 3, data 0xA0..0xA3, AWREADY/WREADY always 1, BRESP=0 ->
//     4 W beats, WLAST on 0xA3 only, done=1 resp=0.
//  2. Read addr 0x100, len 3 -> rd_data 0xA0..0xA3, rd_last on 4th beat, done resp=0.
//  3. AWREADY low 3 cycles, WREADY toggling, rd_ready low 2 cycles mid-read ->
//     AWVALID/AWADDR held stable, no beat lost or duplicated.
//  4. len 0 write; BRESP=2'b10 -> WLAST with first beat, done_resp=2'b10.
//  5. ARESETn low during beat 2 of a len-7 write -> all VALIDs 0 asynchronously;
//     next cmd completes normally.
//  6. Write addr 0xFF8 len 3 (32-bit): with _EN -> no AWVALID, done resp=2'b10;
//     without -> normal 4-beat burst.

Source files
------------

// File: rtl/axi4_burst_master.sv
// ---------------------------------------------------------------------------
// axi4_burst_master
//
// AXI4 initiator driven from a simple command port. Each accepted command
// issues one INCR burst: writes stream beats from the wd_* port onto W, reads
// stream R beats out through the rd_* port. A one-cycle done pulse reports
// completion together with an aggregated response.
//
// Optional feature:
//   AXI4_4K_BOUNDARY_CHECK_EN - when defined, a command whose burst would
//   cross a 4 KiB page is rejected at accept time: no AW/AR/W activity, done
//   pulses the next cycle with SLVERR. When undefined, every command is
//   issued exactly as given.
//
// Ports:
//   ACLK, ARESETn                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (ready while idle)
//   cmd_write/cmd_addr/cmd_len    direction, start address, beats-1
//   wd_data/wd_valid/wd_ready     write beat stream into the master
//   rd_data/rd_valid/rd_last      read beat stream out of the master
//   rd_ready                      read beat sink ready
//   done/done_resp                completion pulse and aggregated response
//   AW*/W*/B*/AR*/R*              AXI4 write/read channels
// ---------------------------------------------------------------------------
module axi4_burst_master #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [DATA_WIDTH-1:0]   wd_data,
    input  logic                    wd_valid,
    output logic                    wd_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    rd_last,
    input  logic                    rd_ready,
    output logic                    done,
    output logic [1:0]              done_resp,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic [7:0]              AWLEN,
    output logic [2:0]              AWSIZE,
    output logic [1:0]              AWBURST,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WVALID,
    output logic                    WLAST,
    input  logic                    WREADY,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic [7:0]              ARLEN,
    output logic [2:0]              ARSIZE,
    output logic [1:0]              ARBURST,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RLAST,
    input  logic                    RVALID,
    output logic                    RREADY
);

    localparam int         BYTES = DATA_WIDTH / 8;
    localparam logic [2:0] SIZE  = 3'($clog2(BYTES));

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WDATA,
        S_WRESP,
        S_RADDR,
        S_RDATA
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [8:0]            r_cnt;
    logic [1:0]            r_acc;

    logic [8:0]            w_lenExt;
    logic                  w_lastBeat;
    logic                  w_overrun;
    logic [1:0]            w_accNext;
    logic                  w_reject;

    assign w_lenExt   = {1'b0, r_len};
    assign w_lastBeat = (r_cnt == w_lenExt);
    // The counter stops at len+1, so any beat the slave sends past the
    // requested length is seen as an overrun beat.
    assign w_overrun  = (r_cnt > w_lenExt);
    assign w_accNext  = (RRESP > r_acc) ? RRESP : r_acc;

`ifdef AXI4_4K_BOUNDARY_CHECK_EN
    logic [ADDR_WIDTH-1:0] w_burstBytes;
    logic [ADDR_WIDTH-1:0] w_endAddr;
    assign w_burstBytes = ADDR_WIDTH'((32'(cmd_len) + 32'd1) * 32'(BYTES));
    assign w_endAddr    = cmd_addr + w_burstBytes - ADDR_WIDTH'(1);
    assign w_reject     = (cmd_addr[ADDR_WIDTH-1:12] != w_endAddr[ADDR_WIDTH-1:12]);
`else
    assign w_reject     = 1'b0;
`endif

    assign cmd_ready = (r_state == S_IDLE);

    assign AWADDR  = r_addr;
    assign AWLEN   = r_len;
    assign AWSIZE  = SIZE;
    assign AWBURST = 2'b01;
    assign ARADDR  = r_addr;
    assign ARLEN   = r_len;
    assign ARSIZE  = SIZE;
    assign ARBURST = 2'b01;

    // W channel is a straight pass-through of the write stream, opened only
    // after the AW handshake has completed.
    assign WDATA    = wd_data;
    assign WSTRB    = '1;
    assign WVALID   = (r_state == S_WDATA) && wd_valid;
    assign wd_ready = (r_state == S_WDATA) && WREADY;
    assign WLAST    = (r_state == S_WDATA) && w_lastBeat;

    // Overrun beats are drained without waiting on the sink and never
    // forwarded to it.
    assign RREADY   = (r_state == S_RDATA) && (w_overrun || rd_ready);
    assign rd_valid = (r_state == S_RDATA) && RVALID && !w_overrun;
    assign rd_last  = rd_valid && RLAST;
    assign rd_data  = RDATA;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            AWVALID   <= 1'b0;
            ARVALID   <= 1'b0;
            BREADY    <= 1'b0;
            done      <= 1'b0;
            done_resp <= 2'b00;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_addr <= cmd_addr;
                        r_len  <= cmd_len;
                        r_cnt  <= '0;
                        r_acc  <= '0;
                        if (w_reject) begin
                            done      <= 1'b1;
                            done_resp <= 2'b10;
                        end else if (cmd_write) begin
                            r_state <= S_WADDR;
                            AWVALID <= 1'b1;
                        end else begin
                            r_state <= S_RADDR;
                            ARVALID <= 1'b1;
                        end
                    end
                end
                S_WADDR: begin
                    if (AWREADY) begin
                        AWVALID <= 1'b0;
                        r_state <= S_WDATA;
                    end
                end
                S_WDATA: begin
                    if (wd_valid && WREADY) begin
                        if (w_lastBeat) begin
                            r_cnt   <= '0;
                            BREADY  <= 1'b1;
                            r_state <= S_WRESP;
                        end else begin
                            r_cnt <= r_cnt + 9'd1;
                        end
                    end
                end
                S_WRESP: begin
                    if (BVALID) begin
                        BREADY    <= 1'b0;
                        done      <= 1'b1;
                        done_resp <= BRESP;
                        r_state   <= S_IDLE;
                    end
                end
                S_RADDR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        r_state <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (RVALID && RREADY) begin
                        if (RLAST) begin
                            // A last beat arriving at any count other than
                            // len means the slave got the length wrong.
                            done      <= 1'b1;
                            done_resp <= w_lastBeat ? w_accNext : 2'b10;
                            r_cnt     <= '0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_acc <= w_accNext;
                            if (!w_overrun) begin
                                r_cnt <= r_cnt + 9'd1;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_burst_master.sv
// ---------------------------------------------------------------------------
// tb_axi4_burst_master
//
// Bench for axi4_burst_master. The bench plays the AXI slave (a word memory
// filled from the W beats the master actually sends) and keeps a separate
// reference memory holding the data it intended to write. Reads are checked
// against the reference memory, so a write or read path fault shows up as a
// data difference. Ready/valid timing is randomised with $urandom.
// Honours AXI4_4K_BOUNDARY_CHECK_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_axi4_burst_master;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [DW-1:0] wd_data;
    logic          wd_valid, wd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_last, rd_ready;
    logic          done;
    logic [1:0]    done_resp;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [7:0]    AWLEN, ARLEN;
    logic [2:0]    AWSIZE, ARSIZE;
    logic [1:0]    AWBURST, ARBURST;
    logic          AWVALID, AWREADY, ARVALID, ARREADY;
    logic [DW-1:0] WDATA;
    logic [3:0]    WSTRB;
    logic          WVALID, WLAST, WREADY;
    logic [1:0]    BRESP;
    logic          BVALID, BREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RLAST, RVALID, RREADY;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] slaveMem [0:16383];
    logic [31:0] refMem   [0:16383];
    logic [31:0] payload  [0:255];
    bit          expDone;
    logic [1:0]  expResp;

    always #5 ACLK = ~ACLK;

    axi4_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_data(wd_data), .wd_valid(wd_valid), .wd_ready(wd_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .done(done), .done_resp(done_resp),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    function automatic int widx(input logic [15:0] a, input int beat);
        return ((int'(a) >> 2) + beat) & 16383;
    endfunction

    function automatic bit crosses4k(input logic [15:0] a, input logic [7:0] len);
        bit r;
        r = 1'b0;
`ifdef AXI4_4K_BOUNDARY_CHECK_EN
        r = (int'(a) / 4096) != ((int'(a) + (int'(len) + 1) * 4 - 1) / 4096);
`endif
        return r;
    endfunction

    // Quiet every slave-side and stream input.
    task automatic idleInputs;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wd_data = '0; wd_valid = 0; rd_ready = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 2'b00;
        ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = 2'b00; RLAST = 0;
    endtask

    task automatic doWrite(input logic [15:0] addr, input logic [7:0] len,
                           input logic [1:0] bresp, input int rdyPct,
                           input int awStall, input int abortBeat);
        int beat, cycles, bDelay;
        bit awDone, bPend, finished, reject;
        beat = 0; cycles = 0; awDone = 0; bPend = 0; finished = 0;
        bDelay = $urandom_range(0, 3);
        reject = crosses4k(addr, len);

        @(negedge ACLK);
        idleInputs();
        cmd_valid = 1; cmd_write = 1; cmd_addr = addr; cmd_len = len;
        #1;
        compared++;
        if (done !== expDone || (expDone && done_resp !== expResp)) begin
            mismatched++;
            $display("[TB] FAIL wr_prev_done: got done=%0b resp=%0d, want done=%0b resp=%0d",
                     done, done_resp, expDone, expResp);
        end
        compared++;
        if (cmd_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL wr_cmd_ready: got %0b, want 1", cmd_ready);
        end
        expDone = 0;

        if (reject) begin
            @(negedge ACLK);
            cmd_valid = 0;
            #1;
            compared++;
            if (done !== 1'b1 || done_resp !== 2'b10 || AWVALID !== 1'b0 ||
                WVALID !== 1'b0 || cmd_ready !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL wr_reject: got done=%0b resp=%0d awvalid=%0b wvalid=%0b, want 1/2/0/0",
                         done, done_resp, AWVALID, WVALID);
            end
            return;
        end

        while (!finished && cycles < 2000) begin
            @(negedge ACLK);
            cycles++;
            cmd_valid = 0;
            AWREADY  = (cycles > awStall) && ($urandom_range(0, 99) < rdyPct);
            WREADY   = ($urandom_range(0, 99) < rdyPct);
            wd_valid = (beat <= int'(len)) && ($urandom_range(0, 99) < rdyPct);
            wd_data  = payload[beat & 255];
            BVALID   = bPend && (bDelay == 0);
            BRESP    = bresp;
            #1;
            compared++;
            if (done !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL wr_early_done: got %0b, want 0", done);
            end
            compared++;
            if (AWVALID !== !awDone) begin
                mismatched++;
                $display("[TB] FAIL wr_awvalid: got %0b, want %0b", AWVALID, !awDone);
            end
            if (AWVALID) begin
                compared++;
                if (AWADDR !== addr || AWLEN !== len || AWSIZE !== 3'd2 || AWBURST !== 2'b01) begin
                    mismatched++;
                    $display("[TB] FAIL wr_aw_fields: got addr=%h len=%0d size=%0d burst=%0d, want %h/%0d/2/1",
                             AWADDR, AWLEN, AWSIZE, AWBURST, addr, len);
                end
            end
            compared++;
            if (WVALID !== (awDone && beat <= int'(len) && wd_valid) ||
                wd_ready !== (awDone && beat <= int'(len) && WREADY)) begin
                mismatched++;
                $display("[TB] FAIL wr_wvalid: got wvalid=%0b wd_ready=%0b at beat %0d", WVALID, wd_ready, beat);
            end
            if (WVALID && WREADY) begin
                compared++;
                if (WDATA !== payload[beat & 255] || WLAST !== (beat == int'(len)) || WSTRB !== 4'hF) begin
                    mismatched++;
                    $display("[TB] FAIL wr_beat%0d: got data=%h last=%0b strb=%h, want %h/%0b/f",
                             beat, WDATA, WLAST, WSTRB, payload[beat & 255], beat == int'(len));
                end
            end
            compared++;
            if (BREADY !== (awDone && beat > int'(len))) begin
                mismatched++;
                $display("[TB] FAIL wr_bready: got %0b at beat %0d", BREADY, beat);
            end
            if (abortBeat >= 0 && beat == abortBeat) return;

            if (AWVALID && AWREADY) awDone = 1;
            if (WVALID && WREADY) begin
                slaveMem[widx(addr, beat)] = WDATA;
                beat++;
                if (beat > int'(len)) bPend = 1;
            end else if (bPend) begin
                if (BVALID && BREADY) finished = 1;
                else if (bDelay > 0) bDelay--;
            end
        end

        if (!finished) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL wr_timeout: burst at %h did not complete, beat=%0d", addr, beat);
        end else begin
            expDone = 1;
            expResp = bresp;
            for (int i = 0; i <= int'(len); i++) refMem[widx(addr, i)] = payload[i];
        end
    endtask

    // lastShift moves the slave's RLAST: 0 on time, +n overrun, -1 early.
    task automatic doRead(input logic [15:0] addr, input logic [7:0] len,
                          input int rdyPct, input int rrMax, input int lastShift);
        int k, cycles, lastIdx, worst;
        bit arDone, finished, overrun;
        logic [1:0] rr [0:299];
        k = 0; cycles = 0; arDone = 0; finished = 0; worst = 0;
        lastIdx = int'(len) + lastShift;
        for (int i = 0; i < 300; i++) rr[i] = 2'($urandom_range(0, rrMax));

        @(negedge ACLK);
        idleInputs();
        cmd_valid = 1; cmd_write = 0; cmd_addr = addr; cmd_len = len;
        #1;
        compared++;
        if (done !== expDone || (expDone && done_resp !== expResp) || cmd_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rd_prev_done: got done=%0b resp=%0d ready=%0b, want done=%0b resp=%0d ready=1",
                     done, done_resp, cmd_ready, expDone, expResp);
        end
        expDone = 0;

        if (crosses4k(addr, len)) begin
            @(negedge ACLK);
            cmd_valid = 0;
            #1;
            compared++;
            if (done !== 1'b1 || done_resp !== 2'b10 || ARVALID !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL rd_reject: got done=%0b resp=%0d arvalid=%0b, want 1/2/0",
                         done, done_resp, ARVALID);
            end
            return;
        end

        while (!finished && cycles < 2000) begin
            @(negedge ACLK);
            cycles++;
            cmd_valid = 0;
            ARREADY  = ($urandom_range(0, 99) < rdyPct);
            RVALID   = arDone && ($urandom_range(0, 99) < rdyPct);
            RDATA    = slaveMem[widx(addr, k)];
            RRESP    = rr[k];
            RLAST    = (k == lastIdx);
            rd_ready = ($urandom_range(0, 99) < rdyPct);
            overrun  = (k > int'(len));
            #1;
            compared++;
            if (done !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL rd_early_done: got %0b, want 0", done);
            end
            compared++;
            if (ARVALID !== !arDone) begin
                mismatched++;
                $display("[TB] FAIL rd_arvalid: got %0b, want %0b", ARVALID, !arDone);
            end
            if (ARVALID) begin
                compared++;
                if (ARADDR !== addr || ARLEN !== len || ARSIZE !== 3'd2 || ARBURST !== 2'b01) begin
                    mismatched++;
                    $display("[TB] FAIL rd_ar_fields: got addr=%h len=%0d size=%0d burst=%0d, want %h/%0d/2/1",
                             ARADDR, ARLEN, ARSIZE, ARBURST, addr, len);
                end
            end
            compared++;
            if (RREADY !== (arDone && (overrun || rd_ready)) ||
                rd_valid !== (arDone && RVALID && !overrun)) begin
                mismatched++;
                $display("[TB] FAIL rd_handshake: got rready=%0b rd_valid=%0b at beat %0d", RREADY, rd_valid, k);
            end
            if (RVALID && !overrun && arDone) begin
                compared++;
                if (rd_data !== refMem[widx(addr, k)] || rd_last !== (k == lastIdx)) begin
                    mismatched++;
                    $display("[TB] FAIL rd_beat%0d: got data=%h last=%0b, want %h/%0b",
                             k, rd_data, rd_last, refMem[widx(addr, k)], k == lastIdx);
                end
            end
            if (ARVALID && ARREADY) arDone = 1;
            if (RVALID && RREADY) begin
                if (int'(RRESP) > worst) worst = int'(RRESP);
                if (RLAST) finished = 1;
                k++;
            end
        end

        if (!finished) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL rd_timeout: burst at %h did not complete, beat=%0d", addr, k);
        end else begin
            expDone = 1;
            expResp = (lastIdx != int'(len)) ? 2'b10 : 2'(worst);
        end
    endtask

    task automatic test_reset;
        idleInputs();
        ARESETn = 0;
        wd_valid = 1; WREADY = 1; rd_ready = 1; RVALID = 1; AWREADY = 1; ARREADY = 1; BVALID = 1;
        #1;
        compared++;
        if (AWVALID !== 0 || ARVALID !== 0 || WVALID !== 0 || BREADY !== 0 || RREADY !== 0 ||
            wd_ready !== 0 || rd_valid !== 0 || done !== 0 || done_resp !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL reset_state: aw=%0b ar=%0b w=%0b b=%0b r=%0b wdr=%0b rdv=%0b done=%0b resp=%0d",
                     AWVALID, ARVALID, WVALID, BREADY, RREADY, wd_ready, rd_valid, done, done_resp);
        end
        repeat (3) @(negedge ACLK);
        idleInputs();
        ARESETn = 1;
        expDone = 0;
    endtask

    task automatic test_basic_write;
        for (int i = 0; i < 4; i++) payload[i] = 32'hA0 + 32'(i);
        doWrite(16'h0100, 8'd3, 2'b00, 100, 0, -1);
    endtask

    task automatic test_basic_read;
        doRead(16'h0100, 8'd3, 100, 0, 0);
    endtask

    task automatic test_stalls;
        for (int i = 0; i < 256; i++) payload[i] = $urandom;
        doWrite(16'h0200, 8'd7, 2'b00, 50, 3, -1);
        doRead(16'h0200, 8'd7, 50, 3, 0);
    endtask

    task automatic test_len0;
        payload[0] = $urandom;
        doWrite(16'h0300, 8'd0, 2'b10, 100, 0, -1);
        doRead(16'h0300, 8'd0, 70, 1, 0);
    endtask

    task automatic test_reset_mid_burst;
        for (int i = 0; i < 256; i++) payload[i] = $urandom;
        doWrite(16'h0400, 8'd7, 2'b00, 100, 0, 2);
        wd_valid = 1; WREADY = 1; rd_ready = 1;
        #2;
        ARESETn = 0;
        #1;
        compared++;
        if (AWVALID !== 0 || WVALID !== 0 || ARVALID !== 0 || BREADY !== 0 || RREADY !== 0 || done !== 0) begin
            mismatched++;
            $display("[TB] FAIL async_reset: aw=%0b w=%0b ar=%0b b=%0b r=%0b done=%0b, want all 0",
                     AWVALID, WVALID, ARVALID, BREADY, RREADY, done);
        end
        repeat (2) @(negedge ACLK);
        idleInputs();
        ARESETn = 1;
        expDone = 0;
        for (int i = 0; i < 256; i++) payload[i] = $urandom;
        doWrite(16'h0400, 8'd7, 2'b01, 80, 0, -1);
        doRead(16'h0400, 8'd7, 80, 0, 0);
    endtask

    task automatic test_4k;
        for (int i = 0; i < 4; i++) payload[i] = $urandom;
        doWrite(16'h0FF8, 8'd3, 2'b00, 100, 0, -1);
        doRead(16'h0FF8, 8'd3, 100, 0, 0);
    endtask

    task automatic test_read_mismatch;
        for (int i = 0; i < 256; i++) payload[i] = $urandom;
        doWrite(16'h0500, 8'd5, 2'b00, 100, 0, -1);
        doRead(16'h0500, 8'd5, 60, 0, 2);
        doRead(16'h0500, 8'd5, 60, 0, -1);
        doRead(16'h0500, 8'd5, 60, 0, 0);
    endtask

    task automatic test_back_to_back;
        logic [15:0] a;
        logic [7:0]  l;
        for (int n = 0; n < 10; n++) begin
            a = 16'h1000 + 16'($urandom_range(0, 1023) * 4);
            l = 8'($urandom_range(0, 15));
            for (int i = 0; i < 256; i++) payload[i] = $urandom;
            doWrite(a, l, 2'($urandom_range(0, 3)), 100, 0, -1);
            doRead(a, l, 100, 3, 0);
        end
    endtask

    task automatic test_final_done;
        @(negedge ACLK);
        idleInputs();
        #1;
        compared++;
        if (done !== expDone || (expDone && done_resp !== expResp)) begin
            mismatched++;
            $display("[TB] FAIL final_done: got done=%0b resp=%0d, want done=%0b resp=%0d",
                     done, done_resp, expDone, expResp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            slaveMem[i] = '0;
            refMem[i]   = '0;
        end
        expDone = 0;
        expResp = 2'b00;
        test_reset();
        test_basic_write();
        test_basic_read();
        test_stalls();
        test_len0();
        test_reset_mid_burst();
        test_4k();
        test_read_mismatch();
        test_back_to_back();
        test_final_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
